// File: rtl/if_id_stage.sv
// IF/ID boundary: PC register, single-outstanding fetch, one-entry skid buffer and the
// IF/ID pipeline register with opcode pre-decode into the immediate-type select.
module if_id_stage #(
  parameter int unsigned       DWIDTH   = 32,
  parameter int unsigned       IWIDTH   = 32,
  parameter logic [DWIDTH-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [DWIDTH-1:0] imem_addr,
  input  logic [IWIDTH-1:0] imem_rdata,
  input  logic              imem_valid,
  input  logic              stall,
  input  logic              flush,
  input  logic [DWIDTH-1:0] redirect_pc,
  output logic              id_valid,
  output logic [DWIDTH-1:0] id_pc,
  output logic [IWIDTH-1:0] id_inst,
  output logic [2:0]        id_immsel,
  output logic              id_illegal
);

  localparam logic [IWIDTH-1:0] Nop = IWIDTH'(32'h0000_0013);

  typedef enum logic [0:0] {StFetch, StSkid} state_e;

  state_e            state_q, state_d;
  logic [DWIDTH-1:0] pc_q, pc_d;
  logic [DWIDTH-1:0] skid_pc_q, skid_pc_d;
  logic [IWIDTH-1:0] skid_inst_q, skid_inst_d;
  logic              id_valid_q, id_valid_d;
  logic [DWIDTH-1:0] id_pc_q, id_pc_d;
  logic [IWIDTH-1:0] id_inst_q, id_inst_d;
  logic [2:0]        id_immsel_q, id_immsel_d;
  logic              id_illegal_q, id_illegal_d;

  logic              accept, load, skid_full;
  logic [IWIDTH-1:0] src_inst;
  logic [DWIDTH-1:0] src_pc;
  logic [2:0]        src_immsel;

  function automatic logic [2:0] immsel_of(input logic [6:0] opcode);
    case (opcode)
      7'b0010011, 7'b0000011, 7'b1100111, 7'b0110011, 7'b1110011: immsel_of = 3'b000;
      7'b0100011:                                                 immsel_of = 3'b001;
      7'b1100011:                                                 immsel_of = 3'b010;
      7'b0110111, 7'b0010111:                                     immsel_of = 3'b011;
      7'b1101111:                                                 immsel_of = 3'b100;
      default:                                                    immsel_of = 3'b111;
    endcase
  endfunction

  // The skid buffer is full exactly when the FSM sits in StSkid.
  assign skid_full  = (state_q == StSkid);
  assign imem_req   = (state_q == StFetch) && !rst;
  assign imem_addr  = pc_q;
  assign accept     = imem_valid && (state_q == StFetch);
  assign load       = !id_valid_q || !stall;
  assign src_inst   = skid_full ? skid_inst_q : imem_rdata;
  assign src_pc     = skid_full ? skid_pc_q : pc_q;
  assign src_immsel = immsel_of(src_inst[6:0]);

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    skid_pc_d    = skid_pc_q;
    skid_inst_d  = skid_inst_q;
    id_valid_d   = id_valid_q;
    id_pc_d      = id_pc_q;
    id_inst_d    = id_inst_q;
    id_immsel_d  = id_immsel_q;
    id_illegal_d = id_illegal_q;

    if (flush) begin
      state_d      = StFetch;
      pc_d         = redirect_pc;
      id_valid_d   = 1'b0;
      id_inst_d    = Nop;
      id_immsel_d  = 3'b000;
      id_illegal_d = 1'b0;
    end else begin
      if (accept) pc_d = pc_q + DWIDTH'(4);
      if (load) begin
        if (skid_full || accept) begin
          state_d      = StFetch;
          id_valid_d   = 1'b1;
          id_pc_d      = src_pc;
          id_inst_d    = src_inst;
          id_immsel_d  = src_immsel;
          id_illegal_d = (src_immsel == 3'b111);
        end else begin
          // Bubble: payload fields keep their last values.
          id_valid_d = 1'b0;
        end
      end else if (accept) begin
        skid_inst_d = imem_rdata;
        skid_pc_d   = pc_q;
        state_d     = StSkid;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StFetch;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q         <= RESET_PC;
      skid_pc_q    <= '0;
      skid_inst_q  <= Nop;
      id_valid_q   <= 1'b0;
      id_pc_q      <= '0;
      id_inst_q    <= Nop;
      id_immsel_q  <= 3'b000;
      id_illegal_q <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      skid_pc_q    <= skid_pc_d;
      skid_inst_q  <= skid_inst_d;
      id_valid_q   <= id_valid_d;
      id_pc_q      <= id_pc_d;
      id_inst_q    <= id_inst_d;
      id_immsel_q  <= id_immsel_d;
      id_illegal_q <= id_illegal_d;
    end
  end

  assign id_valid   = id_valid_q;
  assign id_pc      = id_pc_q;
  assign id_inst    = id_inst_q;
  assign id_immsel  = id_immsel_q;
  assign id_illegal = id_illegal_q;

endmodule

// File: doc/if_id_stage.md
# if_id_stage

Instruction-fetch / decode boundary stage of the RISC-V pipeline. Owns the PC register and issues single-outstanding fetches to instruction memory. Holds a one-entry skid buffer for backpressure and registers the fetched instruction into the IF/ID pipeline register. Pre-decodes the opcode into the 3-bit immediate-type select, so the decode stage can drive the immediate generator (`id_inst[31:7]`, `id_immsel`) directly from registers.

## Interface
- `DWIDTH`, 32: PC / address width.
- `IWIDTH`, 32: instruction width.
- `RESET_PC`, 0: PC value loaded on reset.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset. Asynchronous, active-high.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  DWIDTH  fetch address; always equals the PC register.
- `imem_rdata`  in  IWIDTH  instruction data; sampled only when `imem_valid` and `imem_req` are both high.
- `imem_valid`  in  1  response for the current `imem_addr`. May arrive in the same cycle as the request or any later cycle.
- `stall`  in  1  decode cannot accept a new instruction.
- `flush`  in  1  redirect; discard all fetched state.
- `redirect_pc`  in  DWIDTH  new PC; used only when `flush` is high.
- `id_valid`  out  1  IF/ID register holds a live instruction.
- `id_pc`  out  DWIDTH  PC of `id_inst`.
- `id_inst`  out  IWIDTH  registered instruction; bits `[IWIDTH-1:7]` feed the immediate generator.
- `id_immsel`  out  3  immediate type: 000 I, 001 S, 010 SB, 011 U, 100 UJ, 111 none/illegal.
- `id_illegal`  out  1  opcode is not recognised.

## Operation
**Fetch protocol**
- Held-address protocol: while `imem_req` is high, `imem_addr` stays stable until `imem_valid`, unless `flush` is asserted.
- There is never more than one transaction outstanding.

**FSM states**
- S_FETCH: `imem_req`=1.
- S_SKID: `imem_req`=0; the skid buffer is full.

**Accept**: `imem_valid` && state==S_FETCH. On accept, pc <= pc+4 (wraps modulo 2^DWIDTH).

**IF/ID load**: the register loads when `!id_valid || !stall`. Source priority:
1. Skid buffer, if full.
2. Accepted response.
3. Otherwise the register takes a bubble: `id_valid`<=0.

**Accept while IF/ID is held** (`id_valid && stall`)
- The response goes to the skid buffer along with its PC; the FSM moves to S_SKID.
- In S_SKID with `!stall`: the skid buffer moves into IF/ID and the FSM returns to S_FETCH. A new request issues the following cycle.

**Flush** has the highest priority, overriding stall, accept and skid.
- pc <= `redirect_pc`; `id_valid` <= 0; IF/ID is loaded with NOP (0x00000013); skid buffer is emptied; FSM moves to S_FETCH.
- An `imem_valid` in the same cycle as `flush` is discarded.

**Pre-decode** of the opcode, `inst[6:0]`, registered together with the instruction:
- 0010011, 0000011, 1100111, 0110011, 1110011 -> 000.
- 0100011 -> 001.
- 1100011 -> 010.
- 0110111, 0010111 -> 011.
- 1101111 -> 100.
- Any other opcode -> 111 with `id_illegal`=1. R-type and SYSTEM return 000 and are legal.

**Bubbles**: when `id_valid`=0 as a bubble, `id_inst`, `id_pc` and `id_immsel` hold their last values. Consumers must qualify them with `id_valid`.

## Timing
**Reset values** (asynchronous, immediate on `rst`):
- pc = `RESET_PC`; `imem_req` = 0 while `rst` is high.
- `id_valid` = 0; `id_pc` = 0; `id_inst` = 0x00000013; `id_immsel` = 000; `id_illegal` = 0.
- FSM = S_FETCH; skid buffer empty.

**First request**: `imem_req`=1 in the first cycle after `rst` deasserts.

**Latency**
- `imem_valid` in cycle N -> `id_valid`=1 with that instruction in cycle N+1.
- With a zero-wait memory, throughput is one instruction per cycle.

**Stall**
- While `stall` and `id_valid` are high, every `id_*` output is frozen.
- The skid buffer absorbs at most one response.

**Stall released from S_SKID**
- The skid instruction appears in IF/ID at the next edge.
- The next fetch response arrives no earlier than one cycle after that.

**Flush**
- `flush` in cycle N -> `imem_addr`=`redirect_pc` and `id_valid`=0 in cycle N+1.
- The first redirected instruction is valid no earlier than N+2.

**Reset mid-transaction**: the outstanding request is abandoned; the memory must tolerate `imem_req` dropping.

## Test plan
- **Reset / straight-line fetch**: reset with `RESET_PC`=0x100, zero-wait memory -> `imem_addr` sequence 0x100, 0x104, 0x108; `id_pc` trails by one cycle; `id_valid` stays 1.
- **Immediate select decode**: fetch 0x00500093, 0x00112223, 0x00208463, 0x123452B7, 0x0080006F, 0x0000007F -> `id_immsel` 000, 001, 010, 011, 100, 111; `id_illegal` high only for the last.
- **Stall with skid**: assert `stall` for 3 cycles while a response arrives -> `id_*` frozen, FSM in S_SKID, `imem_req`=0. After release the skid instruction appears next cycle and no instruction is lost or duplicated.
- **Flush priority**: assert `flush`, `redirect_pc`=0x200 concurrently with `stall`, a full skid and `imem_valid` -> next cycle `id_valid`=0, `id_inst`=0x00000013, `imem_addr`=0x200; the next valid `id_pc`=0x200.
- **Wait states / bubbles**: memory delays `imem_valid` by 3 cycles -> `imem_addr` holds stable, `id_valid`=0 for the gap, and the PC advances exactly once.
- **Async reset mid-stall**: assert `rst` asynchronously with the skid full -> all outputs take reset values immediately, without waiting for a clock edge.
